// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: operating modes and one-shot FSM states.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/prog_counter_tick_prescaler.sv
// Divides enabled cycles down to one tick every prescale_i+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pre_q;

    assign tick_o = enable_i && (pre_q == prescale_i);

    // Disabled cycles hold pre_q, so gaps in enable_i keep the tick phase.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || clear_i) begin
            pre_q <= '0;
        end else if (enable_i) begin
            pre_q <= tick_o ? '0 : pre_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Up/down counter with wrap, saturate and one-shot modes, prescaled tick and sticky overflow.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic                  up_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic [1:0]            mode_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  tc_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    function automatic logic [WIDTH-1:0] clip_to_limit(input logic [WIDTH-1:0] val,
                                                       input logic [WIDTH-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    logic             tick;
    logic             pre_clear;
    logic             is_sat;
    logic             is_oneshot;
    logic             boundary;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] clamp_val;
    logic [WIDTH-1:0] wrap_val;
    state_e           state;

    // A load restarts the prescaler phase as well as the count.
    assign pre_clear = clear_i || load_i;

    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_tick_prescaler (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clear_i   (pre_clear),
        .enable_i  (enable_i),
        .prescale_i(prescale_i),
        .tick_o    (tick)
    );

    assign is_sat     = (mode_i == SAT);
    assign is_oneshot = (mode_i == ONESHOT);
    assign boundary   = up_i ? (count_o >= limit_i) : (count_o == '0);
    assign step_val   = up_i ? count_o + WIDTH'(1) : count_o - WIDTH'(1);
    assign clamp_val  = up_i ? limit_i : '0;
    assign wrap_val   = up_i ? '0 : limit_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clear_i) begin
            count_o <= '0;
            tc_o    <= 1'b0;
            ovf_o   <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
        end else if (load_i) begin
            count_o <= clip_to_limit(load_val_i, limit_i);
            tc_o    <= 1'b0;
            state   <= is_oneshot ? RUN : IDLE;
            busy_o  <= is_oneshot;
        end else begin
            tc_o <= 1'b0;
            if (!is_oneshot) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end
            if (tick) begin
                if (is_oneshot) begin
                    // Only a running one-shot moves; IDLE and DONE hold the count.
                    if (state == RUN) begin
                        if (boundary) begin
                            count_o <= clamp_val;
                            tc_o    <= 1'b1;
                            ovf_o   <= 1'b1;
                            state   <= DONE;
                            busy_o  <= 1'b0;
                        end else begin
                            count_o <= step_val;
                        end
                    end
                end else if (boundary) begin
                    count_o <= is_sat ? clamp_val : wrap_val;
                    tc_o    <= 1'b1;
                    ovf_o   <= 1'b1;
                end else begin
                    count_o <= step_val;
                end
            end
        end
    end

endmodule
